// File: rtl/uart_boot_loader_pkg.sv
// Shared constants and the state encoding for the UART boot loader.
// The optional checksum stage is enabled by defining UART_BOOT_LOADER_CHECKSUM_EN.
package uart_boot_loader_pkg;

  localparam logic RESET                  = 1'b0;
  localparam int   WORD_BYTES             = 4;
  localparam int   DEFAULT_TIMEOUT_CYCLES = 1000000;

  typedef logic [2:0] loader_state_t;

  localparam loader_state_t IDLE = 3'd0;
  localparam loader_state_t HDR  = 3'd1;
  localparam loader_state_t DATA = 3'd2;
  localparam loader_state_t CSUM = 3'd3;
  localparam loader_state_t DONE = 3'd4;
  localparam loader_state_t ERR  = 3'd5;

endpackage

// File: rtl/uart_boot_loader_if.sv
// Byte-stream input, instruction-memory write port and core-control status of the loader.
interface uart_boot_loader_if #(
  parameter int ADDR_WIDTH = 12
);

  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic                  cpu_rst_n;
  logic                  load_done;
  logic                  load_err;

  modport master (
    input  rx_data, rx_valid,
    output mem_we, mem_addr, mem_wdata, cpu_rst_n, load_done, load_err
  );

  modport slave (
    output rx_data, rx_valid,
    input  mem_we, mem_addr, mem_wdata, cpu_rst_n, load_done, load_err
  );

endinterface

// File: rtl/uart_byte_packer.sv
// Assembles four strobed bytes into a little-endian word; word/word_valid are
// combinational so the caller can register the result on the same edge as the last byte.
module uart_byte_packer
  import uart_boot_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data,
  input  logic        strobe,
  input  logic        clear,
  output logic [31:0] word,
  output logic        word_valid
);

  localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

  logic [1:0]  idx;
  logic [23:0] shreg;

  // Newest byte lands on top, so after four strobes the first byte sits in [7:0].
  assign word       = {data, shreg};
  assign word_valid = strobe && !clear && (idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst == RESET) begin
      idx   <= '0;
      shreg <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register update tied to the same edge.
      if (strobe) shreg <= word[31:8];
      if (clear)       idx <= strobe ? 2'd1 : 2'd0;
      else if (strobe) idx <= idx + 2'd1;
    end
  end

endmodule

// File: rtl/uart_boot_loader.sv
// Loads a length-prefixed little-endian word image from a UART byte stream into
// instruction memory, releasing the core once complete. Option: UART_BOOT_LOADER_CHECKSUM_EN.
module uart_boot_loader
  import uart_boot_loader_pkg::*;
#(
  parameter int ADDR_WIDTH     = 12,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input logic              clk,
  input logic              rst,
  uart_boot_loader_if.master bus
);

  localparam logic [32:0]         MAX_WORDS = 33'(1) << ADDR_WIDTH;
  localparam int                  IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0]   IDLE_MAX  = IDLE_W'(TIMEOUT_CYCLES);

`ifdef UART_BOOT_LOADER_CHECKSUM_EN
  localparam loader_state_t END_STATE = CSUM;
  localparam logic          END_DONE  = 1'b0;
`else
  localparam loader_state_t END_STATE = DONE;
  localparam logic          END_DONE  = 1'b1;
`endif

  loader_state_t         state;
  logic [31:0]           n_words;
  logic [ADDR_WIDTH:0]   count;
  logic [31:0]           count_next;
  logic [IDLE_W-1:0]     idle;
  logic                  listening;

  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [31:0]           mem_wdata_q;
  logic                  cpu_rst_n_q;
  logic                  load_done_q;
  logic                  load_err_q;

  logic [31:0]           word;
  logic                  word_valid;
  logic                  pack_strobe;
  logic                  pack_clear;

`ifdef UART_BOOT_LOADER_CHECKSUM_EN
  logic [7:0]            csum;
  assign listening = (state == HDR) || (state == DATA) || (state == CSUM);
`else
  assign listening = (state == HDR) || (state == DATA);
`endif

  assign pack_strobe = bus.rx_valid &&
                       ((state == IDLE) || (state == HDR) || (state == DATA) || (state == ERR));
  assign pack_clear  = (state == ERR);
  assign count_next  = 32'(count) + 32'd1;

  uart_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .data       (bus.rx_data),
    .strobe     (pack_strobe),
    .clear      (pack_clear),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk) begin
    if (rst == RESET) begin
      state       <= IDLE;
      n_words     <= '0;
      count       <= '0;
      idle        <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rst_n_q <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
      csum        <= '0;
`endif
    end else begin
      mem_we_q <= 1'b0;

      // A byte arriving on the expiry cycle wins over the timeout.
      if (listening) begin
        if (bus.rx_valid) begin
          idle <= '0;
        end else if (idle == IDLE_MAX) begin
          state      <= ERR;
          load_err_q <= 1'b1;
        end else begin
          idle <= idle + IDLE_W'(1);
        end
      end

      if (bus.rx_valid) begin
        case (state)
          IDLE: state <= HDR;
          HDR: begin
            if (word_valid) begin
              n_words <= word;
              if (word == 32'd0) begin
                state       <= END_STATE;
                load_done_q <= END_DONE;
                cpu_rst_n_q <= END_DONE;
              end else if ({1'b0, word} > MAX_WORDS) begin
                state      <= ERR;
                load_err_q <= 1'b1;
              end else begin
                state <= DATA;
              end
            end
          end
          DATA: begin
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
            csum <= csum + bus.rx_data;
`endif
            if (word_valid) begin
              mem_we_q    <= 1'b1;
              mem_wdata_q <= word;
              mem_addr_q  <= count[ADDR_WIDTH-1:0];
              count       <= count_next[ADDR_WIDTH:0];
              if (count_next == n_words) begin
                state       <= END_STATE;
                load_done_q <= END_DONE;
                cpu_rst_n_q <= END_DONE;
              end
            end
          end
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
          CSUM: begin
            if (bus.rx_data == csum) begin
              state       <= DONE;
              load_done_q <= 1'b1;
              cpu_rst_n_q <= 1'b1;
            end else begin
              state      <= ERR;
              load_err_q <= 1'b1;
            end
          end
`endif
          ERR: begin
            state      <= HDR;
            load_err_q <= 1'b0;
            count      <= '0;
            mem_addr_q <= '0;
            idle       <= '0;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
          end
          DONE:    ;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.cpu_rst_n = cpu_rst_n_q;
  assign bus.load_done = load_done_q;
  assign bus.load_err  = load_err_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader: directed protocol cases plus randomized
// image loads compared against a stream-level model of the boot protocol.
module tb_uart_boot_loader;

  localparam int AW   = 4;
  localparam int TO   = 100;
  localparam int MAXW = 1 << AW;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_boot_loader_if #(.ADDR_WIDTH(AW)) bus ();

  uart_boot_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] wlog_addr[$];
  logic [31:0] wlog_data[$];
  logic [7:0]  pl[$];

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wlog_addr.push_back(32'(bus.mem_addr));
      wlog_data.push_back(bus.mem_wdata);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    bus.rx_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check({tag, "_we"},    32'(bus.mem_we),    32'd0);
    check({tag, "_addr"},  32'(bus.mem_addr),  32'd0);
    check({tag, "_wdata"}, bus.mem_wdata,      32'd0);
    check({tag, "_done"},  32'(bus.load_done), 32'd0);
    check({tag, "_err"},   32'(bus.load_err),  32'd0);
    check({tag, "_cpurst"},32'(bus.cpu_rst_n), 32'd0);
  endtask

  // Model: header N, then 4*N payload bytes (if N fits), then an optional checksum byte.
  task automatic run_load(input logic [31:0] n, input bit bad_csum, input bit directed,
                          input bit from_err);
    logic [7:0] s[$];
    logic [7:0] sum;
    bit         hdr_err;
    bit         exp_err;
    int         nw;
    int         last;
    hdr_err = (n > 32'(MAXW));
    nw      = hdr_err ? 0 : int'(n);
    if (!directed) begin
      pl.delete();
      for (int i = 0; i < 4 * nw; i++) pl.push_back(8'($urandom));
    end
    sum = 8'd0;
    for (int i = 0; i < 4 * nw; i++) sum = sum + pl[i];
    for (int i = 0; i < 4; i++) s.push_back(n[8*i +: 8]);
    for (int i = 0; i < 4 * nw; i++) s.push_back(pl[i]);
    if (CSUM_EN && !hdr_err) s.push_back(bad_csum ? sum + 8'd1 : sum);
    exp_err = hdr_err || (CSUM_EN && bad_csum);
    wlog_addr.delete();
    wlog_data.delete();
    last = s.size() - 1;
    for (int i = 0; i <= last; i++) begin
      if (i == last) begin
        check("pre_done", 32'(bus.load_done), 32'd0);
        check("pre_err",  32'(bus.load_err),  32'd0);
      end
      send(s[i], (i == last) ? 0 : int'($urandom_range(0, 3)));
      if (i == 0 && from_err) check("retry_clears_err", 32'(bus.load_err), 32'd0);
    end
    check("load_done", 32'(bus.load_done), 32'(!exp_err));
    check("load_err",  32'(bus.load_err),  32'(exp_err));
    check("cpu_rst_n", 32'(bus.cpu_rst_n), 32'(!exp_err));
    if (!exp_err && nw > 0 && !CSUM_EN) check("we_with_done", 32'(bus.mem_we), 32'd1);
    repeat (2) @(negedge clk);
    check("wr_count", 32'(wlog_data.size()), 32'(nw));
    for (int i = 0; i < nw && i < wlog_data.size(); i++) begin
      check($sformatf("wr_addr%0d", i), wlog_addr[i], 32'(i));
      check($sformatf("wr_data%0d", i), wlog_data[i],
            {pl[4*i+3], pl[4*i+2], pl[4*i+1], pl[4*i]});
    end
    if (!exp_err) begin
      send(8'($urandom), 1);
      check("done_hold",   32'(bus.load_done),      32'd1);
      check("no_extra_wr", 32'(wlog_data.size()),   32'(nw));
    end
  endtask

  initial begin
    logic [7:0] hb[$];
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    @(negedge clk);
    do_reset("rst0");

    // Two-word directed image
    pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    run_load(32'd2, 1'b0, 1'b1, 1'b0);

    // Empty image
    do_reset("rst_n0");
    run_load(32'd0, 1'b0, 1'b0, 1'b0);

    // Oversized image, then recovery without reset
    do_reset("rst_big");
    run_load(32'd17, 1'b0, 1'b0, 1'b0);
    run_load(32'd1, 1'b0, 1'b0, 1'b1);

    // Timeout: silence after two payload bytes
    do_reset("rst_to");
    wlog_data.delete();
    hb = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB};
    foreach (hb[i]) send(hb[i], 0);
    repeat (TO) @(negedge clk);
    check("to_before", 32'(bus.load_err), 32'd0);
    @(negedge clk);
    check("to_expire",   32'(bus.load_err),     32'd1);
    check("to_cpurst",   32'(bus.cpu_rst_n),    32'd0);
    check("to_no_write", 32'(wlog_data.size()), 32'd0);

    // Byte arriving exactly on the expiry cycle wins
    do_reset("rst_to2");
    wlog_addr.delete();
    wlog_data.delete();
    foreach (hb[i]) send(hb[i], 0);
    repeat (TO) @(negedge clk);
    send(8'hCC, 0);
    check("to_byte_wins", 32'(bus.load_err), 32'd0);
    repeat (TO) @(negedge clk);
    send(8'hDD, 0);
    check("to_byte_wins2", 32'(bus.load_err), 32'd0);
    if (CSUM_EN) send(8'hAA + 8'hBB + 8'hCC + 8'hDD, 0);
    check("to_done", 32'(bus.load_done), 32'd1);
    @(negedge clk);
    check("to_wr_count", 32'(wlog_data.size()), 32'd1);
    if (wlog_data.size() > 0) check("to_wr_data", wlog_data[0], 32'hDDCCBBAA);

    // Reset halfway through a two-word transfer
    do_reset("rst_mid_pre");
    hb = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h5A, 8'hA5};
    foreach (hb[i]) send(hb[i], int'($urandom_range(0, 2)));
    do_reset("rst_mid");
    run_load(32'd1, 1'b0, 1'b0, 1'b0);

    // Randomized images including the full-memory boundary
    for (int k = 0; k < 5; k++) begin
      do_reset("rst_rand");
      run_load((k == 0) ? 32'(MAXW) : 32'($urandom_range(1, MAXW)), 1'b0, 1'b0, 1'b0);
    end
    do_reset("rst_huge");
    run_load(32'hFFFF_FFF0 | 32'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b0);
    run_load(32'($urandom_range(1, 4)), 1'b0, 1'b0, 1'b1);

`ifdef UART_BOOT_LOADER_CHECKSUM_EN
    do_reset("rst_cs_ok");
    pl = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_load(32'd1, 1'b0, 1'b1, 1'b0);
    do_reset("rst_cs_bad");
    run_load(32'd1, 1'b1, 1'b1, 1'b0);
    run_load(32'($urandom_range(1, MAXW)), 1'b1, 1'b0, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
